// File: rtl/ddr3_arb_pkg.sv
// Shared definitions for the DDR3 Avalon-MM burst arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - *_DEF       : default parameter values for the arbiter and its selector
//   - clog2()     : width helper for the round-robin pointer
package ddr3_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 26;
    localparam int DATA_W_DEF  = 256;
    localparam int BURST_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_CMD   = 2'd2,
        RD_DATA  = 2'd3
    } arb_state_t;

    // Ceiling log2; used at elaboration time only.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector.
//   pending : one bit per requester with a command waiting
//   rr_ptr  : index with highest priority this round
//   pick    : one-hot winner, first pending index at or above rr_ptr
//             (wrapping); zero when nothing is pending
module rr_pick
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = clog2(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick
);

    always_comb begin
        logic       found;
        int         sum;
        logic [PTR_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        sum   = 0;
        idx   = '0;
        // Walk the requesters in priority order starting from rr_ptr.
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = PTR_W'(sum);
            if (!found && pending[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller Avalon-MM slave port
// between NUM_REQ bursting DMA requesters. A grant is held for a whole
// burst, so bursts are never interleaved, and only one read is outstanding.
//   clkin_50, cpu_resetn        : clock, asynchronous active-low reset
//   req_*                       : packed requester-side Avalon-MM ports
//   avm_*                       : master port towards the DDR3 controller
//   grant                       : one-hot current grant, zero when idle
//   busy                        : high whenever a burst is in progress
module ddr3_avl_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic                         clkin_50,
    input  logic                         cpu_resetn,
    input  logic [NUM_REQ-1:0]           req_read,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*BURST_W-1:0]   req_burstcount,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           req_waitrequest,
    output logic [DATA_W-1:0]            req_rdata,
    output logic [NUM_REQ-1:0]           req_rdatavalid,
    output logic                         avm_read,
    output logic                         avm_write,
    output logic [ADDR_W-1:0]            avm_addr,
    output logic [BURST_W-1:0]           avm_burstcount,
    output logic [DATA_W-1:0]            avm_wdata,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_rdata,
    input  logic                         avm_rdatavalid,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy
);

    localparam int PTR_W = clog2(NUM_REQ);

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [BURST_W-1:0] bc_arr    [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign bc_arr[gi]    = req_burstcount[gi*BURST_W +: BURST_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    arb_state_t           state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [BURST_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [BURST_W-1:0]   burst_len_reg, burst_len_next;

    logic [NUM_REQ-1:0]   pending;
    logic [NUM_REQ-1:0]   pick;
    logic [PTR_W-1:0]     gidx;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     rr_ptr_after;
    logic                 last_beat;

    assign pending = req_read | req_write;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr_reg),
        .pick    (pick)
    );

    // One-hot to index for the held grant and the fresh pick.
    always_comb begin
        gidx     = '0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_reg[i]) gidx = PTR_W'(i);
            if (pick[i])      pick_idx = PTR_W'(i);
        end
    end

    assign rr_ptr_after = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    assign last_beat    = (beat_cnt_reg == burst_len_reg - BURST_W'(1));

    // Datapath: commands are qualified by state so that a stalled requester
    // still holding read during RD_DATA cannot issue a second read.
    always_comb begin
        avm_addr        = addr_arr[gidx];
        avm_burstcount  = bc_arr[gidx];
        avm_wdata       = wdata_arr[gidx];
        avm_write       = (state_reg == WR_BURST) && req_write[gidx];
        avm_read        = (state_reg == RD_CMD) && req_read[gidx];
        req_waitrequest = '1;
        if (state_reg == WR_BURST || state_reg == RD_CMD) begin
            req_waitrequest[gidx] = avm_waitrequest;
        end
        req_rdatavalid = '0;
        if (state_reg == RD_DATA) begin
            req_rdatavalid[gidx] = avm_rdatavalid;
        end
    end

    assign req_rdata = avm_rdata;
    assign grant     = grant_reg;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        rr_ptr_next    = rr_ptr_reg;
        beat_cnt_next  = beat_cnt_reg;
        burst_len_next = burst_len_reg;
        case (state_reg)
            IDLE: begin
                if (|pending) begin
                    grant_next     = pick;
                    beat_cnt_next  = '0;
                    // A zero burstcount still moves one beat.
                    burst_len_next = (bc_arr[pick_idx] == '0) ? BURST_W'(1) : bc_arr[pick_idx];
                    state_next     = (|(pick & req_write)) ? WR_BURST : RD_CMD;
                end
            end
            WR_BURST: begin
                if (avm_write && !avm_waitrequest) begin
                    if (last_beat) begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        rr_ptr_next   = rr_ptr_after;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + BURST_W'(1);
                    end
                end
            end
            RD_CMD: begin
                if (avm_read && !avm_waitrequest) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                if (avm_rdatavalid) begin
                    if (last_beat) begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        rr_ptr_next   = rr_ptr_after;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + BURST_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkin_50 or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            rr_ptr_reg    <= '0;
            beat_cnt_reg  <= '0;
            burst_len_reg <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            rr_ptr_reg    <= rr_ptr_next;
            beat_cnt_reg  <= beat_cnt_next;
            burst_len_reg <= burst_len_next;
        end
    end

endmodule
